data_sampling: RTL

DATA_SAMPLING -- requirements
Module: data_sampling

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/data_sampling.sv | 95 +++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
// Holds the legal oversampling ratios, frame length and majority vote.
package uart_rx_pkg;

    localparam int PRESCALE_8     = 8;
    localparam int PRESCALE_16    = 16;
    localparam int PRESCALE_32    = 32;
    localparam int FRAME_BITS_DEF = 11;

    function automatic logic maj3(input logic a,
                                  input logic b,
                                  input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops reset to RST_VAL so the line looks idle out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/data_sampling.sv
// Oversampled bit recovery: 3-sample majority vote around mid-bit.
// Tracks edge/bit position and strobes each recovered bit once.
module data_sampling
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  samp_enable,
    output logic                  samp_data_out,
    output logic                  samp_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(PRESCALE_8);
    localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(PRESCALE_16);
    localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(PRESCALE_32);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    logic                  rx_sync;
    logic [PRESCALE_W-1:0] p_q;
    logic [PRESCALE_W-1:0] p_legal;
    logic [PRESCALE_W-1:0] h;
    logic                  edge_last;
    logic                  s0;
    logic                  s1;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (rx_in),
        .q   (rx_sync)
    );

    // Unsupported ratios fall back to the slowest-clock-safe 8x
    always_comb begin
        p_legal = P8;
        unique case (1'b1)
            (prescale == P16): p_legal = P16;
            (prescale == P32): p_legal = P32;
            default:           p_legal = P8;
        endcase
    end

    assign h         = p_q >> 1;
    assign edge_last = (edge_cnt == p_q - 1'b1);
    assign bit_done  = samp_enable & edge_last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p_q      <= P8;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!samp_enable) begin
            p_q      <= p_legal;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_last) begin
            edge_cnt <= '0;
            bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // Vote uses the two stored samples plus the live one at H+1
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s0            <= 1'b1;
            s1            <= 1'b1;
            samp_data_out <= 1'b1;
            samp_valid    <= 1'b0;
        end else begin
            samp_valid <= 1'b0;
            if (samp_enable) begin
                if (edge_cnt == h - 1'b1) s0 <= rx_sync;
                if (edge_cnt == h)        s1 <= rx_sync;
                if (edge_cnt == h + 1'b1) begin
                    samp_data_out <= maj3(s0, s1, rx_sync);
                    samp_valid    <= 1'b1;
                end
            end
        end
    end

endmodule
